mul_seq: RTL

//  Control sequencer for the shift-and-add multiplier built on the acc datapath (AH/AL shreg pair).

---
 rtl/mul_seq_if.sv | 30 +++
 rtl/mul_seq.sv | 112 +++++++++++
 2 files changed

// File: rtl/mul_seq_if.sv
// Control bundle between the multiply sequencer and the acc datapath.
// slave = sequencer side, master = datapath/host side.
interface mul_seq_if #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH+1)
) ();
  logic          start;
  logic          abort;
  logic          q0;
  logic          ah_inen;
  logic          ah_reset;
  logic [1:0]    hs;
  logic [1:0]    ls;
  logic          add_en;
  logic          cy_ld;
  logic          cy_clr;
  logic          busy;
  logic          done;
  logic [CW-1:0] iter;

  modport slave (
    input  start, abort, q0,
    output ah_inen, ah_reset, hs, ls, add_en, cy_ld, cy_clr, busy, done, iter
  );

  modport master (
    output start, abort, q0,
    input  ah_inen, ah_reset, hs, ls, add_en, cy_ld, cy_clr, busy, done, iter
  );
endinterface

// File: rtl/mul_seq.sv
// Shift-and-add multiply sequencer driving the acc AH/AL shreg pair.
//
// state | meaning
// IDLE  | waiting for start, carry held clear, AH:AL held
// LDA   | multiplier loaded into AH from ah_in
// XFER  | AH copied into AL
// CLRH  | AH and carry cleared, iteration count reset
// TEST  | inspect multiplier LSB (q0)
// ADD   | AH <= AH + M, carry captured
// SHIFT | carry:AH:AL shifted right one place
// DONE  | product valid in AH:AL for one cycle
module mul_seq #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic     clk,
  input  logic     clr,
  mul_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LDA   = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_CLRH  = 3'd3;
  localparam logic [2:0] S_TEST  = 3'd4;
  localparam logic [2:0] S_ADD   = 3'd5;
  localparam logic [2:0] S_SHIFT = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_SHR   = 2'b01;
  localparam logic [1:0] M_LOAD  = 2'b11;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH-1);

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] iter_q;

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state_nxt = S_LDA;
        S_LDA:   state_nxt = S_XFER;
        S_XFER:  state_nxt = S_CLRH;
        S_CLRH:  state_nxt = S_TEST;
        S_TEST:  state_nxt = bus.q0 ? S_ADD : S_SHIFT;
        S_ADD:   state_nxt = S_SHIFT;
        S_SHIFT: state_nxt = (iter_q == LAST_ITER) ? S_DONE : S_TEST;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Iteration counter: reloaded in CLRH, so it can never run past WIDTH.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                    iter_q <= '0;
    else if (bus.abort)          iter_q <= '0;
    else if (state == S_CLRH)    iter_q <= '0;
    else if (state == S_SHIFT)   iter_q <= iter_q + 1'b1;
  end

  // Moore output decode.
  always_comb begin
    bus.ah_inen  = 1'b0;
    bus.ah_reset = 1'b0;
    bus.hs       = M_HOLD;
    bus.ls       = M_HOLD;
    bus.add_en   = 1'b0;
    bus.cy_ld    = 1'b0;
    bus.cy_clr   = 1'b0;
    bus.done     = 1'b0;
    case (state)
      S_IDLE:  bus.cy_clr = 1'b1;
      S_LDA: begin
        bus.ah_inen = 1'b1;
        bus.hs      = M_LOAD;
      end
      S_XFER:  bus.ls = M_LOAD;
      S_CLRH: begin
        bus.ah_reset = 1'b1;
        bus.cy_clr   = 1'b1;
      end
      S_TEST:  bus.cy_clr = 1'b1;
      S_ADD: begin
        bus.add_en = 1'b1;
        bus.hs     = M_LOAD;
        bus.cy_ld  = 1'b1;
      end
      S_SHIFT: begin
        bus.hs = M_SHR;
        bus.ls = M_SHR;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.iter = iter_q;

endmodule
